regfile_host_arbiter: RTL and testbench

- Shares the 32x32 register file's single write port and read port B between the processor core and a host debug agent (UART command decoder).
- The core has priority by default. A host request that waits STARVE_LIMIT cycles forces a one-access core stall.
- Sits between core writeback/decode, the host command decoder, and the regfile instance.

---
 rtl/regfile_host_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_host_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_host_arbiter.sv
// Shares the regfile write port and read port B between the core and the host debug agent.
// Optional REGFILE_HOST_X0_ERR_EN: host writes to x0 are dropped and flagged on host_err.
//
// state  | meaning
// IDLE   | core owns both regfile ports; waiting for a host request
// ARB    | host request pending; granted when the core leaves the ports free
// FORCE  | starvation limit reached; core stalled, host access performed
// RDWAIT | host read in flight; port B held on the host address, core stalled
module regfile_host_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_write,
  input  logic [4:0]  core_wrAddr,
  input  logic [31:0] core_wrData,
  input  logic [4:0]  core_rdAddrB,
  output logic [31:0] core_rdDataB,
  output logic        core_stall,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [4:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
`ifdef REGFILE_HOST_X0_ERR_EN
  output logic        host_err,
`endif
  output logic        rf_write,
  output logic [4:0]  rf_wrAddr,
  output logic [31:0] rf_wrData,
  output logic [4:0]  rf_rdAddrB,
  input  logic [31:0] rf_rdDataB
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    FORCE  = 2'd2,
    RDWAIT = 2'd3
  } arbState_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arbState_t        state, nextState;
  logic [CNT_W-1:0] starveCnt, nextCnt;
  logic             grant;
  logic             stallReq;
  logic             hostPath;
  logic             hostWrEn;
  logic [4:0]       rdAddrQ;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      starveCnt <= '0;
    end else begin
      state     <= nextState;
      starveCnt <= nextCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = starveCnt;
    grant     = 1'b0;
    stallReq  = 1'b0;
    case (state)
      IDLE: begin
        if (host_req) nextState = ARB;
      end
      ARB: begin
        if (!host_req) begin
          // protocol violation: abandon the request rather than hang
          nextState = IDLE;
          nextCnt   = '0;
        end else if (!core_write) begin
          grant     = 1'b1;
          nextCnt   = '0;
          nextState = host_we ? IDLE : RDWAIT;
        end else begin
          nextCnt = (starveCnt == LIMIT) ? starveCnt : starveCnt + CNT_W'(1);
          if (nextCnt == LIMIT) nextState = FORCE;
        end
      end
      FORCE: begin
        stallReq = 1'b1;
        nextCnt  = '0;
        if (host_req) begin
          grant     = 1'b1;
          nextState = host_we ? IDLE : RDWAIT;
        end else begin
          nextState = IDLE;
        end
      end
      RDWAIT: begin
        stallReq  = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Reset aborts any host access combinationally so the core regains the ports at once.
  assign host_gnt   = grant & reset_n;
  assign core_stall = stallReq & reset_n;
  assign hostPath   = reset_n & (grant | (state == RDWAIT));

`ifdef REGFILE_HOST_X0_ERR_EN
  assign hostWrEn = grant & host_we & (host_addr != 5'd0);
  assign host_err = host_gnt & host_we & (host_addr == 5'd0);
`else
  assign hostWrEn = grant & host_we;
`endif

  assign rf_write     = hostPath ? hostWrEn : (core_write & ~core_stall);
  assign rf_wrAddr    = hostPath ? host_addr : core_wrAddr;
  assign rf_wrData    = hostPath ? host_wdata : core_wrData;
  assign rf_rdAddrB   = hostPath ? ((state == RDWAIT) ? rdAddrQ : host_addr) : core_rdAddrB;
  assign core_rdDataB = rf_rdDataB;

  // The host may change host_addr after the grant, so the read address is latched.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdAddrQ     <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      if (grant) rdAddrQ <= host_addr;
      host_rvalid <= (state == RDWAIT);
      if (state == RDWAIT) host_rdata <= rf_rdDataB;
    end
  end

endmodule

// File: tb/tb_regfile_host_arbiter.sv
// Directed bench for regfile_host_arbiter with a behavioural 32x32 regfile (x0 reads 0).
module tb_regfile_host_arbiter;

  logic        clk;
  logic        reset_n;
  logic        core_write;
  logic [4:0]  core_wrAddr;
  logic [31:0] core_wrData;
  logic [4:0]  core_rdAddrB;
  logic [31:0] core_rdDataB;
  logic        core_stall;
  logic        host_req;
  logic        host_we;
  logic [4:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;
`ifdef REGFILE_HOST_X0_ERR_EN
  logic        host_err;
`endif
  logic        rf_write;
  logic [4:0]  rf_wrAddr;
  logic [31:0] rf_wrData;
  logic [4:0]  rf_rdAddrB;
  logic [31:0] rf_rdDataB;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [32];

  regfile_host_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .core_write   (core_write),
    .core_wrAddr  (core_wrAddr),
    .core_wrData  (core_wrData),
    .core_rdAddrB (core_rdAddrB),
    .core_rdDataB (core_rdDataB),
    .core_stall   (core_stall),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_rvalid  (host_rvalid),
    .host_rdata   (host_rdata),
`ifdef REGFILE_HOST_X0_ERR_EN
    .host_err     (host_err),
`endif
    .rf_write     (rf_write),
    .rf_wrAddr    (rf_wrAddr),
    .rf_wrData    (rf_wrData),
    .rf_rdAddrB   (rf_rdAddrB),
    .rf_rdDataB   (rf_rdDataB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_write && rf_wrAddr != 5'd0) mem[rf_wrAddr] <= rf_wrData;
  assign rf_rdDataB = (rf_rdAddrB == 5'd0) ? 32'd0 : mem[rf_rdAddrB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Host write; expLat = negedges from request to grant (1 idle core, 9 when forced).
  task automatic hostWrite(input logic [4:0] addr, input logic [31:0] data, input int expLat,
                           input logic expWr, input string tag);
    int n;
    int stallEarly;
    n = 0;
    stallEarly = 0;
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = addr; host_wdata = data;
    do begin
      @(negedge clk); #1;
      n++;
      if (core_stall && !host_gnt) stallEarly++;
    end while (!host_gnt && n < 20);
    chk({tag, "_gnt"}, host_gnt, 1'b1);
    chk({tag, "_lat"}, n, expLat);
    chk({tag, "_stall_before_gnt"}, stallEarly, 0);
    chk({tag, "_stall_at_gnt"}, core_stall, (expLat > 1) ? 1'b1 : 1'b0);
    chk({tag, "_rf_write"}, rf_write, expWr);
    chk({tag, "_rf_wrAddr"}, rf_wrAddr, addr);
    chk({tag, "_rf_wrData"}, rf_wrData, data);
`ifdef REGFILE_HOST_X0_ERR_EN
    chk({tag, "_host_err"}, host_err, (addr == 5'd0) ? 1'b1 : 1'b0);
`endif
    @(negedge clk); #1;
    chk({tag, "_no_b2b_gnt"}, host_gnt, 1'b0);
    chk({tag, "_stall_after"}, core_stall, 1'b0);
    host_req = 1'b0;
  endtask

  // Host read with idle core; a core write attempted during RDWAIT must be blocked.
  task automatic hostRead(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = addr;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!host_gnt && n < 20);
    chk({tag, "_gnt"}, host_gnt, 1'b1);
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_rdAddrB_gnt"}, rf_rdAddrB, addr);
    @(negedge clk);
    host_req = 1'b0; host_addr = 5'h1F;
    core_write = 1'b1; core_wrAddr = 5'd20; core_wrData = 32'h0BAD_0BAD;
    #1;
    chk({tag, "_stall_rdwait"}, core_stall, 1'b1);
    chk({tag, "_rdAddrB_held"}, rf_rdAddrB, addr);
    chk({tag, "_core_wr_blocked"}, rf_write, 1'b0);
    chk({tag, "_rvalid_early"}, host_rvalid, 1'b0);
    @(negedge clk);
    core_write = 1'b0;
    #1;
    chk({tag, "_rvalid"}, host_rvalid, 1'b1);
    chk({tag, "_rdata"}, host_rdata, exp);
    chk({tag, "_stall_after"}, core_stall, 1'b0);
  endtask

  initial begin
    logic gntSeen;
    logic expX0Wr;
    reset_n = 1'b0;
    core_write = 1'b0; core_wrAddr = '0; core_wrData = '0; core_rdAddrB = 5'd9;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_gnt", host_gnt, 1'b0);
    chk("rst_rvalid", host_rvalid, 1'b0);
    chk("rst_rdata", host_rdata, 32'd0);
    chk("rst_rdAddrB_core", rf_rdAddrB, 5'd9);
    reset_n = 1'b1;

    // idle core: host write then read back
    hostWrite(5'd5, 32'hDEAD_BEEF, 1, 1'b1, "wr_x5");
    hostRead(5'd5, 32'hDEAD_BEEF, "rd_x5");

    // core writes every cycle: host is forced after 8 ARB cycles
    @(negedge clk);
    core_write = 1'b1; core_wrAddr = 5'd10; core_wrData = 32'h0000_AAAA;
    hostWrite(5'd7, 32'h0000_1234, 9, 1'b1, "force_x7");
    @(negedge clk);
    core_write = 1'b0; core_rdAddrB = 5'd10;
    #1;
    chk("core_rd_x10", core_rdDataB, 32'h0000_AAAA);
    hostRead(5'd7, 32'h0000_1234, "rd_x7");

    // x0 write is never stored; read returns 0
`ifdef REGFILE_HOST_X0_ERR_EN
    expX0Wr = 1'b0;
`else
    expX0Wr = 1'b1;
`endif
    hostWrite(5'd0, 32'hFFFF_FFFF, 1, expX0Wr, "wr_x0");
    hostRead(5'd0, 32'd0, "rd_x0");

    // reset during RDWAIT aborts the read
    hostWrite(5'd6, 32'h0000_6666, 1, 1'b1, "wr_x6");
    hostRead(5'd6, 32'h0000_6666, "rd_x6");
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'd7;
    @(negedge clk); #1;
    chk("rstrd_gnt", host_gnt, 1'b1);
    @(negedge clk);
    host_req = 1'b0; reset_n = 1'b0; core_rdAddrB = 5'd10;
    #1;
    chk("rstrd_stall_in_reset", core_stall, 1'b0);
    chk("rstrd_rdAddrB_core", rf_rdAddrB, 5'd10);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rstrd_rvalid", host_rvalid, 1'b0);
    chk("rstrd_rdata", host_rdata, 32'd0);
    chk("rstrd_stall", core_stall, 1'b0);
    chk("rstrd_gnt_after", host_gnt, 1'b0);
    @(negedge clk);
    core_write = 1'b1; core_wrAddr = 5'd3; core_wrData = 32'h0000_0033;
    #1;
    chk("rstrd_rvalid_late", host_rvalid, 1'b0);
    chk("core_wr_x3", rf_write, 1'b1);
    chk("core_wrAddr_x3", rf_wrAddr, 5'd3);
    @(negedge clk);
    core_write = 1'b0; core_rdAddrB = 5'd3;
    #1;
    chk("core_rd_x3", core_rdDataB, 32'h0000_0033);

    // request dropped after 3 ARB cycles; the retry must wait the full limit again
    @(negedge clk);
    core_write = 1'b1; core_wrAddr = 5'd11; core_wrData = 32'h0000_000B;
    host_req = 1'b1; host_we = 1'b1; host_addr = 5'd9; host_wdata = 32'h0000_0099;
    gntSeen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      gntSeen = gntSeen | host_gnt;
    end
    chk("drop_no_gnt", gntSeen, 1'b0);
    @(negedge clk);
    host_req = 1'b0;
    #1;
    chk("drop_gnt_low", host_gnt, 1'b0);
    @(negedge clk); #1;
    chk("drop_idle_stall", core_stall, 1'b0);
    chk("drop_idle_gnt", host_gnt, 1'b0);
    hostWrite(5'd9, 32'h0000_0099, 9, 1'b1, "fresh_x9");
    @(negedge clk);
    core_write = 1'b0;
    hostRead(5'd9, 32'h0000_0099, "rd_x9");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
